// File: rtl/ga_pkg.sv
// Shared definitions for the genome mutator: FSM state encoding, default
// sizing and the gene-position width helper.
package ga_pkg;

  localparam int GENOME_BITS_DEF = 32;
  localparam int ATTEMPTS_DEF    = 4;
  localparam int COUNT_W         = 4;  // holds attempt counts up to 15

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ_RATE  = 3'd1,
    S_WAIT_RATE = 3'd2,
    S_REQ_POS   = 3'd3,
    S_WAIT_POS  = 3'd4,
    S_FINISH    = 3'd5
  } state_t;

  // Number of low byte bits that address one gene of the genome.
  function automatic int pos_width(input int genome_bits);
    return (genome_bits <= 2) ? 1 : $clog2(genome_bits);
  endfunction

endpackage

// File: rtl/genome_mutator.sv
// Mutates one genome per request. Each of ATTEMPTS trials draws a rate byte
// from the external generator; when that byte is below the requested rate a
// position byte is drawn and the addressed gene is flipped (XOR).
module genome_mutator
  import ga_pkg::*;
#(
  parameter int GENOME_BITS = GENOME_BITS_DEF,
  parameter int ATTEMPTS    = ATTEMPTS_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_start,
  input  logic [GENOME_BITS-1:0] in_genome,
  input  logic [7:0]             in_rate,
  output logic                   prng_start,
  input  logic [7:0]             prng_value,
  input  logic                   prng_done,
  output logic [GENOME_BITS-1:0] out_genome,
  output logic                   out_valid,
  output logic                   busy
);

  localparam int POS_W = pos_width(GENOME_BITS);
  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(ATTEMPTS);

  state_t                 r_state;
  logic [COUNT_W-1:0]     r_count;
  logic [GENOME_BITS-1:0] r_work;
  logic [GENOME_BITS-1:0] r_out_genome;
  logic [7:0]             r_rate;
  logic                   r_prng_start;
  logic                   r_out_valid;
  logic                   r_busy;

  state_t                 w_next;
  logic [COUNT_W-1:0]     w_count_next;
  logic [GENOME_BITS-1:0] w_work_next;
  logic [GENOME_BITS-1:0] w_flip_mask;
  logic                   w_trial_end;
  logic                   w_accept;

  assign w_accept    = (r_state == S_IDLE) && in_start;
  // Only the low POS_W bits of the position byte select a gene.
  assign w_flip_mask = GENOME_BITS'(1) << prng_value[POS_W-1:0];

  // Next-state, next-count and next-working-genome decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_next       = r_state;
    w_count_next = r_count;
    w_work_next  = r_work;
    w_trial_end  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_start) begin
          w_next       = S_REQ_RATE;
          w_work_next  = in_genome;
          w_count_next = '0;
        end
      end
      S_REQ_RATE: w_next = S_WAIT_RATE;
      S_WAIT_RATE: begin
        if (prng_done) begin
          if (prng_value < r_rate) w_next = S_REQ_POS;
          else                     w_trial_end = 1'b1;
        end
      end
      S_REQ_POS: w_next = S_WAIT_POS;
      S_WAIT_POS: begin
        if (prng_done) begin
          w_work_next = r_work ^ w_flip_mask;
          w_trial_end = 1'b1;
        end
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase

    if (w_trial_end) begin
      w_count_next = r_count + 1'b1;
      w_next       = (w_count_next == LAST_COUNT) ? S_FINISH : S_REQ_RATE;
    end
  end

  // State, working registers and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: data registers are reset too, because out_genome must read 0 right after reset.
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_work       <= '0;
      r_rate       <= '0;
      r_out_genome <= '0;
      r_prng_start <= 1'b0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      r_state      <= w_next;
      r_count      <= w_count_next;
      r_work       <= w_work_next;
      if (w_accept) r_rate <= in_rate;
      r_prng_start <= (w_next == S_REQ_RATE) || (w_next == S_REQ_POS);
      r_out_valid  <= (w_next == S_FINISH);
      r_busy       <= (w_next != S_IDLE);
      // The final flip lands on the same edge that enters FINISH.
      if (w_next == S_FINISH) r_out_genome <= w_work_next;
    end
  end

  assign prng_start = r_prng_start;
  assign out_genome = r_out_genome;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;

endmodule

// File: tb/tb_genome_mutator.sv
// Self-checking bench for genome_mutator: scripted and random byte streams
// from a behavioural generator, a transaction-level mutation model, and a
// per-cycle monitor on out_genome / out_valid / prng_start.
module tb_genome_mutator;

  localparam int GB      = 32;
  localparam int ATT     = 4;
  localparam int GEN_LAT = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_start = 1'b0;
  logic [GB-1:0] in_genome = '0;
  logic [7:0]    in_rate = '0;
  logic          prng_start;
  logic [7:0]    prng_value = '0;
  logic          prng_done = 1'b0;
  logic [GB-1:0] out_genome;
  logic          out_valid;
  logic          busy;

  genome_mutator #(.GENOME_BITS(GB), .ATTEMPTS(ATT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_start   (in_start),
    .in_genome  (in_genome),
    .in_rate    (in_rate),
    .prng_start (prng_start),
    .prng_value (prng_value),
    .prng_done  (prng_done),
    .out_genome (out_genome),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [7:0]    byte_q[$];
  logic [GB-1:0] exp_out    = '0;
  logic [GB-1:0] exp_result = '0;
  bit            run_open   = 1'b0;
  bit            got_valid  = 1'b0;
  bit            prev_start = 1'b0;
  int            n_req      = 0;
  int            n_done     = 0;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: apply the mutation rules to a byte stream; report bytes used.
  function automatic logic [GB-1:0] model(input logic [GB-1:0] g, input logic [7:0] r,
                                          input logic [7:0] b[$], output int used);
    logic [GB-1:0] x;
    logic [7:0]    rate_byte;
    logic [7:0]    pos_byte;
    int            k;
    x = g;
    k = 0;
    for (int t = 0; t < ATT; t++) begin
      rate_byte = b[k];
      k++;
      if (rate_byte < r) begin
        pos_byte = b[k];
        k++;
        x[int'(pos_byte) % GB] = ~x[int'(pos_byte) % GB];
      end
    end
    used = k;
    return x;
  endfunction

  // Generator: answers each request GEN_LAT cycles later with the next scripted byte.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      prng_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          prng_done  = 1'b1;
          prng_value = (byte_q.size() > 0) ? byte_q.pop_front() : 8'($urandom);
          n_done++;
        end
      end
      if (prng_start === 1'b1) cnt = GEN_LAT;
    end
  end

  // Per-cycle monitor: held result, single out_valid per run, one-cycle requests.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prng_start === 1'b1) begin
        n_req++;
        check(!prev_start, "prng_start_one_cycle", 64'(prng_start), 64'd0);
      end
      prev_start = (prng_start === 1'b1);
      if (out_valid === 1'b1) begin
        check(run_open && !got_valid, "out_valid_expected", 64'(out_valid), 64'd0);
        check(out_genome === exp_result, "out_genome_result", 64'(out_genome), 64'(exp_result));
        exp_out   = exp_result;
        got_valid = 1'b1;
      end else begin
        check(out_genome === exp_out, "out_genome_held", 64'(out_genome), 64'(exp_out));
      end
    end else begin
      prev_start = 1'b0;
    end
  end

  // One request: poke >= 2 re-pulses in_start mid-run with a different genome.
  task automatic run(input logic [GB-1:0] g, input logic [7:0] r, input logic [7:0] bytes[$],
                     input logic [GB-1:0] want, input int want_n, input int poke,
                     input string name);
    bit fin;
    byte_q     = bytes;
    exp_result = want;
    n_req      = 0;
    got_valid  = 1'b0;
    run_open   = 1'b1;
    fin        = 1'b0;
    @(negedge clk); #1;
    in_start  = 1'b1;
    in_genome = g;
    in_rate   = r;
    for (int i = 0; i < 4000 && !fin; i++) begin
      @(negedge clk); #1;
      if (i == 0) begin
        in_start  = 1'b0;
        in_genome = $urandom;
        in_rate   = 8'($urandom);
      end
      if (i == poke) begin
        in_start  = 1'b1;
        in_genome = 32'h1234_5678;
        in_rate   = 8'hFF;
      end else if (i == poke + 1) begin
        in_start  = 1'b0;
      end
      check(busy === 1'b1, {name, "_busy_high"}, 64'(busy), 64'd1);
      if (got_valid) fin = 1'b1;
    end
    check(fin, {name, "_timeout"}, 64'(fin), 64'd1);
    @(negedge clk); #1;
    check(busy === 1'b0, {name, "_busy_low_after"}, 64'(busy), 64'd0);
    check(n_req == want_n, {name, "_prng_requests"}, 64'(n_req), 64'(want_n));
    run_open = 1'b0;
    byte_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    logic [7:0]    s[$];
    logic [GB-1:0] g;
    logic [GB-1:0] want;
    logic [7:0]    r;
    int            used;
    int            done_before;
    bit            ok;

    // Reset values.
    repeat (3) @(negedge clk);
    #1;
    check(busy === 1'b0,       "reset_busy",       64'(busy),       64'd0);
    check(out_valid === 1'b0,  "reset_out_valid",  64'(out_valid),  64'd0);
    check(prng_start === 1'b0, "reset_prng_start", 64'(prng_start), 64'd0);
    check(out_genome === '0,   "reset_out_genome", 64'(out_genome), 64'd0);
    rst_n = 1'b1;

    // Pin the model against hand-worked results.
    s = {8'h00, 8'h00, 8'h00, 8'h00};
    want = model(32'hDEAD_BEEF, 8'h00, s, used);
    check(want == 32'hDEAD_BEEF && used == 4, "model_rate0", 64'(want), 64'hDEAD_BEEF);
    s = {8'h10, 8'h03, 8'h20, 8'h05, 8'h40, 8'hFF, 8'h90};
    want = model(32'h0, 8'h80, s, used);
    check(want == 32'h8000_0028 && used == 7, "model_three_flips", 64'(want), 64'h8000_0028);
    s = {8'h00, 8'h07, 8'h00, 8'h07, 8'hFF, 8'hFF};
    want = model(32'h80, 8'hFF, s, used);
    check(want == 32'h80 && used == 6, "model_same_bit", 64'(want), 64'h80);

    // Rate 0 never mutates: one byte per trial.
    s = {8'h00, 8'h00, 8'h00, 8'h00};
    run(32'hDEAD_BEEF, 8'h00, s, 32'hDEAD_BEEF, 4, -1, "rate_zero");
    // Three flips at bits 3, 5 and 31 (0xFF masked to 31).
    s = {8'h10, 8'h03, 8'h20, 8'h05, 8'h40, 8'hFF, 8'h90};
    run(32'h0, 8'h80, s, 32'h8000_0028, 7, -1, "three_flips");
    // Same bit hit twice is restored.
    s = {8'h00, 8'h07, 8'h00, 8'h07, 8'hFF, 8'hFF};
    run(32'h80, 8'hFF, s, 32'h80, 6, -1, "same_bit_twice");
    // Rate 255 with byte 0xFF draws no position.
    s = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run(32'h5A5A_5A5A, 8'hFF, s, 32'h5A5A_5A5A, 4, -1, "rate_max_ff");
    // Rate 1 with byte 0 draws a position (bit 4).
    s = {8'h00, 8'h04, 8'h01, 8'h01, 8'h01};
    run(32'h0, 8'h01, s, 32'h10, 5, -1, "rate_one_zero");
    // in_start during WAIT_RATE is ignored; trial 2 uses byte == rate (no flip).
    s = {8'h3F, 8'h1F, 8'h40, 8'hFF, 8'h00, 8'h00};
    run(32'hCAFE_F00D, 8'h40, s, 32'h4AFE_F00C, 6, 2, "start_while_busy");

    // Reset in WAIT_POS, then a stray generator byte.
    byte_q   = {8'h00, 8'h05};
    n_req    = 0;
    run_open = 1'b1;
    got_valid = 1'b0;
    @(negedge clk); #1;
    in_start  = 1'b1;
    in_genome = 32'hFFFF_0000;
    in_rate   = 8'hFF;
    @(negedge clk); #1;
    in_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      if (n_req == 2) ok = 1'b1;
    end
    check(ok, "reset_test_pos_request", 64'(n_req), 64'd2);
    repeat (3) @(negedge clk);
    #1;
    done_before = n_done;
    rst_n    = 1'b0;
    exp_out  = '0;
    run_open = 1'b0;
    #1;
    check(busy === 1'b0,       "midrun_reset_busy",       64'(busy),       64'd0);
    check(out_valid === 1'b0,  "midrun_reset_out_valid",  64'(out_valid),  64'd0);
    check(prng_start === 1'b0, "midrun_reset_prng_start", 64'(prng_start), 64'd0);
    check(out_genome === '0,   "midrun_reset_out_genome", 64'(out_genome), 64'd0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      check(busy === 1'b0,       "stray_done_busy",       64'(busy),       64'd0);
      check(prng_start === 1'b0, "stray_done_prng_start", 64'(prng_start), 64'd0);
    end
    check(n_done == done_before + 1, "stray_done_delivered", 64'(n_done), 64'(done_before + 1));
    byte_q.delete();

    // A fresh run after the interrupted one.
    s = {8'h00, 8'h00, 8'h00, 8'h00};
    run(32'hDEAD_BEEF, 8'h00, s, 32'hDEAD_BEEF, 4, -1, "after_reset");

    // Randomized runs against the model.
    for (int n = 0; n < 24; n++) begin
      g = $urandom;
      case (n % 4)
        0:       r = 8'($urandom_range(0, 2));
        1:       r = 8'($urandom_range(253, 255));
        default: r = 8'($urandom);
      endcase
      s.delete();
      for (int k = 0; k < 2 * ATT; k++) begin
        if ($urandom_range(0, 3) == 0) s.push_back(8'hFF);
        else                           s.push_back(8'($urandom));
      end
      want = model(g, r, s, used);
      run(g, r, s, want, used, -1, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
